decompress_stream: RTL and testbench

DECOMPRESS_STREAM -- requirements
Module: decompress_stream

---
 rtl/decompress_stream.sv | 102 ++++++++++
 tb/tb_decompress_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decompress_stream.sv
// Two-stage decompressor: (x*Q + 2^(D-1)) >> D with a running output index.
// Define DECOMPRESS_LAST_CHECK_EN to add the sticky in_last mismatch flag err.
module decompress_stream #(
  parameter int D          = 10,
  parameter int Q          = 3329,
  parameter int NUM_COEFFS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [D-1:0] in_coeff,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [11:0]  out_coeff,
  output logic [7:0]   out_index,
  output logic         out_last
`ifdef DECOMPRESS_LAST_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam int PW = D + 12;
  localparam logic [PW-1:0] RND = PW'(1) << (D - 1);
  localparam logic [7:0] LAST = 8'(NUM_COEFFS - 1);

  logic          s1_v;
  logic [PW-1:0] s1_prod;
  logic [PW-1:0] prod;
  logic          in_fire;
  logic          out_fire;
  logic          s2_ld;
  logic [7:0]    cnt_nxt;
  logic          unused_lo;

  assign prod     = PW'(in_coeff) * PW'(Q) + RND;
  assign in_ready = !(s1_v && out_valid && !out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign s2_ld    = s1_v && (!out_valid || out_ready);
  assign cnt_nxt  = (out_index == LAST) ? 8'd0 : out_index + 8'd1;
  assign unused_lo = ^s1_prod[D-1:0];

  // out_index is the output counter itself; it only moves on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_prod   <= '0;
      out_valid <= 1'b0;
      out_coeff <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (flush) begin
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_v    <= 1'b1;
        s1_prod <= prod;
      end else if (s2_ld) begin
        s1_v    <= 1'b0;
      end
      if (s2_ld) begin
        out_valid <= 1'b1;
        out_coeff <= s1_prod[PW-1:D];
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_fire) begin
        out_index <= cnt_nxt;
        out_last  <= (cnt_nxt == LAST);
      end
    end
  end

`ifdef DECOMPRESS_LAST_CHECK_EN
  logic [7:0] in_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt <= '0;
      err    <= 1'b0;
    end else if (flush) begin
      in_cnt <= '0;
      err    <= 1'b0;
    end else if (in_fire) begin
      in_cnt <= (in_cnt == LAST) ? 8'd0 : in_cnt + 8'd1;
      if (in_last != (in_cnt == LAST))
        err <= 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = in_last;
`endif

endmodule

// File: tb/tb_decompress_stream.sv
// Bench for decompress_stream: random streams against a queue-based model.
// Also exercises a D=4 instance and, when defined, DECOMPRESS_LAST_CHECK_EN.
module tb_decompress_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_coeff;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coeff;
  logic [7:0]  out_index;
  logic        out_last;
  logic        err;

  logic        f4;
  logic        v4;
  logic        r4;
  logic [3:0]  c4;
  logic        l4;
  logic        ov4;
  logic        or4;
  logic [11:0] oc4;
  logic [7:0]  oi4;
  logic        ol4;
  logic        err4;

  always #5 clk = ~clk;

  decompress_stream #(.D(10), .Q(3329), .NUM_COEFFS(256)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_coeff(in_coeff), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coeff(out_coeff), .out_index(out_index),
    .out_last(out_last)
`ifdef DECOMPRESS_LAST_CHECK_EN
    , .err(err)
`endif
  );

  decompress_stream #(.D(4), .Q(3329), .NUM_COEFFS(256)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(f4),
    .in_valid(v4), .in_ready(r4),
    .in_coeff(c4), .in_last(l4),
    .out_valid(ov4), .out_ready(or4),
    .out_coeff(oc4), .out_index(oi4),
    .out_last(ol4)
`ifdef DECOMPRESS_LAST_CHECK_EN
    , .err(err4)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int icnt = 0;
  int eidx = 0;
  int q[$];
  int acc[$];
  bit bad_last = 1'b0;

  function automatic int dec(input int x, input int d);
    return (x * 3329 + (1 << (d - 1))) >> d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    acc.delete();
    eidx = 0;
    icnt = 0;
  endtask

  // one cycle: drive, compare against model, update model, advance
  task automatic step(input bit iv, input int d, input bit ordy,
                      input bit fl);
    bit ev;
    bit er;
    in_valid  = iv;
    in_coeff  = d[9:0];
    out_ready = ordy;
    flush     = fl;
    in_last   = bad_last ? (icnt == 200) : (icnt == 255);
    #1;
    ev = 1'b0;
    if (q.size() > 0) ev = (cyc - acc[0] >= 2);
    er = !(q.size() == 2 && !ordy);
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_coeff", out_coeff, q[0]);
      chk("out_index", out_index, eidx);
      chk("out_last", out_last, eidx == 255);
    end
    if (fl) begin
      clear_model();
    end else begin
      if (ev && ordy) begin
        void'(q.pop_front());
        void'(acc.pop_front());
        eidx = (eidx + 1) % 256;
      end
      if (iv && er) begin
        q.push_back(dec(d, 10));
        acc.push_back(cyc);
        icnt = (icnt + 1) % 256;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_coeff"}, out_coeff, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  initial begin
    int vals[4];
    int e4;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_coeff = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    f4 = 1'b0;
    v4 = 1'b0;
    c4 = '0;
    l4 = 1'b0;
    or4 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // spec points for D=10
    vals = '{0, 1, 512, 1023};
    foreach (vals[i]) step(1, vals[i], 1, 0);
    repeat (3) step(0, 0, 1, 0);
    chk("d10_model_1023", dec(1023, 10), 3326);

    // full polynomial back-to-back, then into the next one
    step(0, 0, 1, 1);
    repeat (262) step(1, $urandom_range(1023), 1, 0);
    repeat (3) step(0, 0, 1, 0);

    // 5-cycle backpressure mid-stream
    repeat (10) step(1, $urandom_range(1023), 1, 0);
    repeat (5) step(1, $urandom_range(1023), 0, 0);
    repeat (10) step(1, $urandom_range(1023), 1, 0);
    repeat (3) step(0, 0, 1, 0);

    // random valid/ready patterns
    repeat (600)
      step($urandom_range(3) != 0, $urandom_range(1023),
           $urandom_range(3) != 0, 0);
    repeat (4) step(0, 0, 1, 0);

    // flush coinciding with a handshake
    repeat (3) step(1, $urandom_range(1023), 1, 0);
    step(1, $urandom_range(1023), 1, 1);
    repeat (3) step(0, 0, 1, 0);
    repeat (5) step(1, $urandom_range(1023), 1, 0);
    repeat (3) step(0, 0, 1, 0);

    // asynchronous reset after 100 coefficients
    repeat (100) step(1, $urandom_range(1023), 1, 0);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    chk("async_rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    clear_model();
    repeat (6) step(1, $urandom_range(1023), 1, 0);
    repeat (3) step(0, 0, 1, 0);

`ifdef DECOMPRESS_LAST_CHECK_EN
    chk("err_clean", err, 0);
    bad_last = 1'b1;
    repeat (210) step(1, $urandom_range(1023), 1, 0);
    #1 chk("err_set", err, 1);
    bad_last = 1'b0;
    repeat (30) step(1, $urandom_range(1023), 1, 0);
    #1 chk("err_held", err, 1);
    step(0, 0, 1, 1);
    #1 chk("err_flushed", err, 0);
`endif

    // D=4 instance: literal spec points then random
    e4 = 0;
    for (int k = 0; k < 6; k++) begin
      int x;
      int ex;
      x  = (k == 0) ? 8 : (k == 1) ? 15 : $urandom_range(15);
      ex = (k == 0) ? 1665 : (k == 1) ? 3121 : dec(x, 4);
      v4 = 1'b1;
      c4 = x[3:0];
      @(negedge clk);
      v4 = 1'b0;
      @(negedge clk);
      #1;
      chk("d4_valid", ov4, 1);
      chk("d4_coeff", oc4, ex);
      chk("d4_index", oi4, e4);
      e4++;
    end
    @(negedge clk);
    #1 chk("d4_drained", ov4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
